// File: rtl/tone_sample_gen.sv
// Tone sample generator: square-wave audio word with attack/sustain/release envelope.
// Latency: sample/sample_valid registered, valid exactly 1 cycle after each sample_req.
// Backpressure: none; state advances only on sample_req strobes. Macro ENVELOPE_EN enables ramps.
module tone_sample_gen #(
    parameter logic [15:0] AMPLITUDE = 16'h2000,
    parameter logic [15:0] ENV_STEP  = 16'h0400
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         half_period,
    input  logic               sample_req,
    output logic signed [15:0] sample,
    output logic               sample_valid,
    output logic               active
);

`ifdef ENVELOPE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ATTACK = 2'd1, SUSTAIN = 2'd2, RELEASE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SUSTAIN = 2'd2} state_t;
`endif

    state_t      state, state_nxt;
    logic [15:0] env, env_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        pol, pol_nxt;
    logic [7:0]  cur_period;
    logic [7:0]  per_eff;
    logic        key;
    logic        wrap;
    logic [7:0]  step_cnt;
    logic        step_pol;
    logic [15:0] sample_nxt;

    // A held key (nonzero period) takes effect on the same request it is seen.
    assign key     = (half_period != 8'd0);
    assign per_eff = key ? half_period : cur_period;

    // Phase advance: wrap when the count has reached period-1 (or a shrunken period passed it).
    assign wrap     = ({1'b0, cnt} + 9'd1) >= {1'b0, per_eff};
    assign step_cnt = wrap ? 8'd0 : cnt + 8'd1;
    assign step_pol = wrap ? ~pol : pol;

`ifdef ENVELOPE_EN
    logic [16:0] env_up, env_dn;
    logic [15:0] up_sat, dn_sat;

    // 17-bit envelope arithmetic so ramps clamp instead of wrapping.
    assign env_up = {1'b0, env} + {1'b0, ENV_STEP};
    assign env_dn = {1'b0, env} - {1'b0, ENV_STEP};
    assign up_sat = (env_up >= {1'b0, AMPLITUDE}) ? AMPLITUDE : env_up[15:0];
    assign dn_sat = env_dn[16] ? 16'd0 : env_dn[15:0];

    // Next state per request; a transition applies the destination's envelope action at once.
    always_comb begin
        state_nxt = state;
        env_nxt   = env;
        cnt_nxt   = cnt;
        pol_nxt   = pol;
        case (state)
            IDLE: begin
                env_nxt = 16'd0;
                if (key) begin
                    cnt_nxt   = 8'd0;
                    pol_nxt   = 1'b1;
                    env_nxt   = up_sat;
                    state_nxt = (up_sat == AMPLITUDE) ? SUSTAIN : ATTACK;
                end
            end
            ATTACK, RELEASE: begin
                cnt_nxt = step_cnt;
                pol_nxt = step_pol;
                if (key) begin
                    env_nxt   = up_sat;
                    state_nxt = (up_sat == AMPLITUDE) ? SUSTAIN : ATTACK;
                end else begin
                    env_nxt   = dn_sat;
                    state_nxt = (dn_sat == 16'd0) ? IDLE : RELEASE;
                end
            end
            SUSTAIN: begin
                cnt_nxt = step_cnt;
                pol_nxt = step_pol;
                if (key) begin
                    env_nxt = AMPLITUDE;
                end else begin
                    env_nxt   = dn_sat;
                    state_nxt = (dn_sat == 16'd0) ? IDLE : RELEASE;
                end
            end
            default: begin
                state_nxt = IDLE;
                env_nxt   = 16'd0;
            end
        endcase
    end
`else
    logic unused_env_step;
    assign unused_env_step = ^ENV_STEP;

    // Gate-only envelope: full amplitude while a key is held, phase restarts on key-down.
    always_comb begin
        state_nxt = state;
        env_nxt   = env;
        cnt_nxt   = cnt;
        pol_nxt   = pol;
        if (key) begin
            env_nxt   = AMPLITUDE;
            state_nxt = SUSTAIN;
            if (state == IDLE) begin
                cnt_nxt = 8'd0;
                pol_nxt = 1'b1;
            end else begin
                cnt_nxt = step_cnt;
                pol_nxt = step_pol;
            end
        end else begin
            env_nxt   = 16'd0;
            state_nxt = IDLE;
        end
    end
`endif

    // Output word from the post-update envelope and polarity; silence is always +0.
    always_comb begin
        sample_nxt = 16'd0;
        if (env_nxt != 16'd0)
            sample_nxt = pol_nxt ? env_nxt : (16'd0 - env_nxt);
    end

    // Registers advance only on a request; valid mirrors the request one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            env          <= 16'd0;
            cnt          <= 8'd0;
            pol          <= 1'b1;
            cur_period   <= 8'd0;
            sample       <= 16'sd0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= sample_req;
            if (sample_req) begin
                state  <= state_nxt;
                env    <= env_nxt;
                cnt    <= cnt_nxt;
                pol    <= pol_nxt;
                sample <= sample_nxt;
                if (key)
                    cur_period <= half_period;
            end
        end
    end

    assign active = (state != IDLE);

endmodule

// File: doc/tone_sample_gen.md
TONE_SAMPLE_GEN -- requirements
Module: tone_sample_gen

Interface
REQ-001 The module SHALL have parameter AMPLITUDE, default 16'h2000, meaning peak sample magnitude (positive, below 16'h8000).
REQ-002 The module SHALL have parameter ENV_STEP, default 16'h0400, meaning envelope increment or decrement applied per sample request.
REQ-003 The module SHALL have port clk, input, 1 bit: single system clock (12.288 MHz).
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port half_period, input, 8 bits: tone half-period in samples from the period selector; 0 means no key held.
REQ-006 The module SHALL have port sample_req, input, 1 bit: one-cycle strobe from the I2S transmitter requesting the next 48 kHz sample.
REQ-007 The module SHALL have port sample, output, 16 bits, signed two's-complement: audio word for the transmitter.
REQ-008 The module SHALL have port sample_valid, output, 1 bit: one-cycle pulse marking a new sample.
REQ-009 The module SHALL have port active, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-010 The module SHALL act only on clk edges where sample_req=1; all other cycles SHALL hold every register.
REQ-011 sample and sample_valid SHALL be registered, with sample_valid asserted exactly 1 cycle after each sample_req; sample SHALL hold between requests.
REQ-012 At each request with half_period!=0, the module SHALL latch half_period into cur_period.
REQ-013 The phase counter SHALL be 8 bits; on each request it SHALL increment, or wrap to 0 and toggle polarity when it is >= cur_period-1, so a period shrinking below the count wraps on the next request.
REQ-014 The output SHALL be sample = polarity ? +env : -env, computed from values after the current update, with sample = 0 whenever env = 0.
REQ-015 The state machine SHALL have four states: IDLE, ATTACK, SUSTAIN, RELEASE.
REQ-016 In IDLE with half_period!=0: go to ATTACK, clear the counter, set polarity to 1.
REQ-017 In ATTACK: env += ENV_STEP, saturating at AMPLITUDE; on reaching AMPLITUDE go to SUSTAIN; if half_period=0 go to RELEASE.
REQ-018 In SUSTAIN: env = AMPLITUDE; if half_period=0 go to RELEASE.
REQ-019 In RELEASE: env -= ENV_STEP, saturating at 0, while oscillating at cur_period; if half_period!=0 go to ATTACK without clearing the phase; on reaching env=0 go to IDLE.
REQ-020 In IDLE, env and sample SHALL be 0 and the counter and polarity SHALL hold.
REQ-021 A half_period change during ATTACK or SUSTAIN SHALL take effect at the next request with no phase reset and no envelope change.
REQ-022 Envelope arithmetic SHALL use 17 bits internally so that overflow and underflow are clamped, never wrapped.

Reset
REQ-023 rst SHALL asynchronously force: state=IDLE, env=0, counter=0, polarity=1, cur_period=0, sample=0, sample_valid=0, active=0.
REQ-024 rst SHALL override a simultaneous sample_req.
REQ-025 Reset mid-tone SHALL produce no sample_valid until the first request after rst deasserts.

Configuration
REQ-026 The macro ENVELOPE_EN SHALL control the envelope.
REQ-027 With ENVELOPE_EN defined, behaviour SHALL be as REQ-015..REQ-019.
REQ-028 Without ENVELOPE_EN, ATTACK and RELEASE SHALL not exist, and on each request env SHALL equal half_period!=0 ? AMPLITUDE : 0.
REQ-029 Without ENVELOPE_EN, the state SHALL be SUSTAIN when half_period!=0 and IDLE otherwise, with the phase cleared on the IDLE->SUSTAIN transition; ENV_STEP SHALL be unused.

Verification
REQ-030 Reset, then 3 requests with half_period=0 -> 3 sample_valid pulses with sample=0 and active=0.
REQ-031 ENVELOPE_EN, defaults, half_period=4 held for 20 requests -> env 0x0400,0x0800..0x2000 reached at request 8, then SUSTAIN; sign pattern +,+,+,+,-,-,-,- repeating from request 1.
REQ-032 From SUSTAIN, half_period=0 -> 8 requests ramp |sample| down 0x1C00..0x0000, with polarity still toggling every 4 requests; IDLE and active=0 after the 8th.
REQ-033 During RELEASE at env=0x1000, half_period=6 -> ATTACK with no phase reset, env 0x1400 on the next request, new toggle interval 6.
REQ-034 In SUSTAIN with counter=5 and period 8, switch to half_period=3 -> wrap and polarity toggle on the next request.
REQ-035 rst pulsed mid-ATTACK coincident with sample_req -> all outputs 0 immediately and no sample_valid; without ENVELOPE_EN, the first request at half_period=4 -> sample=+0x2000.
